decode_stage_p: RTL and testbench

Parametrised decode stage for the core pipeline. It holds the general-purpose register file and reads two source operands with write-back bypass. Operand 1 is taken from the input port when the control bundle requests it. The control bundle, operands and destination index are registered into a valid/ready pipeline register with stall back-pressure and flush. It sits between fetch (upstream) and execute (downstream), and takes the write-back port from the last stage.

---
 rtl/decode_stage_p_if.sv | 40 ++++
 rtl/decode_stage_p.sv | 90 +++++++++
 tb/tb_decode_stage_p.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_p_if.sv
// Handshake and data bundle for the decode stage: fetch-side beat, write-back port,
// flush, and the registered execute-side beat.
interface decode_stage_p_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CTRL_W = 23
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] ctrl_in;
    logic [ADDR_W-1:0] rsrc1;
    logic [ADDR_W-1:0] rsrc2;
    logic [ADDR_W-1:0] rdst_in;
    logic [DATA_W-1:0] in_port;

    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              flush;

    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] ctrl_out;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [ADDR_W-1:0] rdst_out;

    modport master (
        output in_valid, ctrl_in, rsrc1, rsrc2, rdst_in, in_port,
        output wb_en, wb_addr, wb_data, flush, out_ready,
        input  in_ready, out_valid, ctrl_out, read_data1, read_data2, rdst_out
    );

    modport slave (
        input  in_valid, ctrl_in, rsrc1, rsrc2, rdst_in, in_port,
        input  wb_en, wb_addr, wb_data, flush, out_ready,
        output in_ready, out_valid, ctrl_out, read_data1, read_data2, rdst_out
    );
endinterface

// File: rtl/decode_stage_p.sv
// Decode stage: register file with write-through bypass, operand-1 input-port mux,
// and a valid/ready output register with stall and flush.
module decode_stage_p #(
    parameter int DATA_W     = 16,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_W     = $clog2(NUM_REGS),
    parameter int CTRL_W     = 23,
    parameter int IN_SEL_BIT = 18,
    parameter int ZERO_REG   = 0
) (
    input logic            clk,
    input logic            rst,
    decode_stage_p_if.slave bus
);
    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              wb_write;
    logic [DATA_W-1:0] rf1;
    logic [DATA_W-1:0] rf2;
    logic [DATA_W-1:0] op1;
    logic              ready;
    logic              accept;

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data1_q;
    logic [DATA_W-1:0] data2_q;
    logic [ADDR_W-1:0] rdst_q;

    // With a hardwired zero register, write-back to index 0 is dropped here so the
    // bypass path never forwards it either.
    assign wb_write = bus.wb_en && !((ZERO_REG != 0) && (bus.wb_addr == '0));

    // NOTE: the register file has a defined all-zero reset state, so every entry is
    // cleared in the async reset branch rather than left to power-up contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_write) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // NOTE: each output gets its default first, so no path leaves it unassigned and
    // no latch is inferred; the later ifs then override in priority order.
    always_comb begin
        rf1 = regs[bus.rsrc1];
        rf2 = regs[bus.rsrc2];
        if (wb_write && (bus.wb_addr == bus.rsrc1)) rf1 = bus.wb_data;
        if (wb_write && (bus.wb_addr == bus.rsrc2)) rf2 = bus.wb_data;
        if ((ZERO_REG != 0) && (bus.rsrc1 == '0)) rf1 = '0;
        if ((ZERO_REG != 0) && (bus.rsrc2 == '0)) rf2 = '0;
        op1 = bus.ctrl_in[IN_SEL_BIT] ? bus.in_port : rf1;
    end

    // Flush forces ready so the incoming beat is swallowed rather than left pending.
    assign ready  = !valid_q || bus.out_ready || bus.flush;
    assign accept = bus.in_valid && ready && !bus.flush;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data1_q <= '0;
            data2_q <= '0;
            rdst_q  <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            ctrl_q  <= bus.ctrl_in;
            data1_q <= op1;
            data2_q <= rf2;
            rdst_q  <= bus.rdst_in;
        end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = valid_q;
    assign bus.ctrl_out   = ctrl_q;
    assign bus.read_data1 = data1_q;
    assign bus.read_data2 = data2_q;
    assign bus.rdst_out   = rdst_q;
endmodule

// File: tb/tb_decode_stage_p.sv
// Directed bench for decode_stage_p: scoreboard of expected beats against a register
// model, plus a ZERO_REG=1 instance for the hardwired-zero behaviour.
module tb_decode_stage_p;
    localparam int DATA_W     = 16;
    localparam int NUM_REGS   = 8;
    localparam int ADDR_W     = 3;
    localparam int CTRL_W     = 23;
    localparam int IN_SEL_BIT = 18;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
        logic [ADDR_W-1:0] rd;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   sent = 0;
    int   rcvd = 0;
    int   dropped = 0;
    beat_t sb[$];
    logic [DATA_W-1:0] mregs [NUM_REGS];

    always #5 clk = ~clk;

    decode_stage_p_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) bus ();
    decode_stage_p_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) bus_z ();

    decode_stage_p #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W),
        .IN_SEL_BIT(IN_SEL_BIT), .ZERO_REG(0)
    ) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    decode_stage_p #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W),
        .IN_SEL_BIT(IN_SEL_BIT), .ZERO_REG(1)
    ) dut_z (.clk(clk), .rst(rst), .bus(bus_z.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_rd(input logic [ADDR_W-1:0] a);
        if (bus.wb_en && (bus.wb_addr == a)) return bus.wb_data;
        return mregs[a];
    endfunction

    task automatic drive_beat(input logic v, input logic [CTRL_W-1:0] c,
                              input logic [ADDR_W-1:0] s1, input logic [ADDR_W-1:0] s2,
                              input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] ip);
        bus.in_valid = v;
        bus.ctrl_in  = c;
        bus.rsrc1    = s1;
        bus.rsrc2    = s2;
        bus.rdst_in  = d;
        bus.in_port  = ip;
    endtask

    task automatic drive_wb(input logic en, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] dat);
        bus.wb_en   = en;
        bus.wb_addr = a;
        bus.wb_data = dat;
    endtask

    // One clock: compare at the falling edge, update the model, return just after the rising edge.
    task automatic step();
        bit    model_ready;
        beat_t e;
        @(negedge clk);
        model_ready = (sb.size() == 0) || (bus.out_ready === 1'b1);
        check("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
        check("in_ready", 32'(bus.in_ready), 32'(model_ready || (bus.flush === 1'b1)));
        if (sb.size() != 0) begin
            check("ctrl_out", 32'(bus.ctrl_out), 32'(sb[0].ctrl));
            check("read_data1", 32'(bus.read_data1), 32'(sb[0].d1));
            check("read_data2", 32'(bus.read_data2), 32'(sb[0].d2));
            check("rdst_out", 32'(bus.rdst_out), 32'(sb[0].rd));
        end
        if (bus.flush) begin
            dropped += sb.size();
            sb.delete();
        end else begin
            if ((sb.size() != 0) && bus.out_ready) begin
                void'(sb.pop_front());
                rcvd++;
            end
            if (bus.in_valid && model_ready) begin
                e.ctrl = bus.ctrl_in;
                e.d1   = bus.ctrl_in[IN_SEL_BIT] ? bus.in_port : model_rd(bus.rsrc1);
                e.d2   = model_rd(bus.rsrc2);
                e.rd   = bus.rdst_in;
                sb.push_back(e);
                sent++;
            end
        end
        if (bus.wb_en) mregs[bus.wb_addr] = bus.wb_data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) mregs[i] = '0;
        drive_beat(1'b0, '0, '0, '0, '0, '0);
        drive_wb(1'b0, '0, '0);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        bus_z.in_valid = 1'b0;
        bus_z.ctrl_in  = '0;
        bus_z.rsrc1    = '0;
        bus_z.rsrc2    = '0;
        bus_z.rdst_in  = '0;
        bus_z.in_port  = '0;
        bus_z.wb_en    = 1'b0;
        bus_z.wb_addr  = '0;
        bus_z.wb_data  = '0;
        bus_z.flush    = 1'b0;
        bus_z.out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_ctrl_out", 32'(bus.ctrl_out), 32'd0);
        check("rst_read_data1", 32'(bus.read_data1), 32'd0);
        check("rst_read_data2", 32'(bus.read_data2), 32'd0);
        check("rst_rdst_out", 32'(bus.rdst_out), 32'd0);
        check("z_rst_out_valid", 32'(bus_z.out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Write R3 and R1 by write-back, then read R3 from storage
        drive_wb(1'b1, 3'd3, 16'h1234);
        step();
        drive_wb(1'b1, 3'd1, 16'h7777);
        step();
        drive_wb(1'b0, '0, '0);
        drive_beat(1'b1, 23'h012345, 3'd3, 3'd3, 3'd6, 16'h0000);
        step();
        drive_beat(1'b0, '0, '0, '0, '0, '0);
        check("r3_read_data1", 32'(bus.read_data1), 32'h1234);
        check("r3_read_data2", 32'(bus.read_data2), 32'h1234);
        step();

        // Bypass, in-port select, then storage read of the bypassed value, back to back
        drive_wb(1'b1, 3'd5, 16'hBEEF);
        drive_beat(1'b1, 23'h000ABC, 3'd2, 3'd5, 3'd1, 16'h0000);
        step();
        drive_wb(1'b0, '0, '0);
        check("bypass_read_data2", 32'(bus.read_data2), 32'hBEEF);
        drive_beat(1'b1, 23'h7FFFFF, 3'd1, 3'd1, 3'd7, 16'h00A5);
        step();
        check("inport_read_data1", 32'(bus.read_data1), 32'h00A5);
        check("inport_read_data2", 32'(bus.read_data2), 32'h7777);
        drive_beat(1'b1, 23'h000000, 3'd5, 3'd3, 3'd2, 16'h0000);
        step();
        drive_beat(1'b0, '0, '0, '0, '0, '0);
        step();

        // Same-index bypass on both operands, with and without in-port select
        drive_wb(1'b1, 3'd4, 16'h4444);
        drive_beat(1'b1, 23'h000004, 3'd4, 3'd4, 3'd4, 16'h0F0F);
        step();
        drive_wb(1'b1, 3'd4, 16'h5555);
        drive_beat(1'b1, 23'h040004, 3'd4, 3'd4, 3'd5, 16'h0F0F);
        step();
        drive_wb(1'b0, '0, '0);
        drive_beat(1'b0, '0, '0, '0, '0, '0);
        step();

        // Stall for three cycles with a beat pending, then release
        drive_beat(1'b1, 23'h0000A1, 3'd3, 3'd5, 3'd3, 16'h0000);
        step();
        bus.out_ready = 1'b0;
        drive_beat(1'b1, 23'h0000B2, 3'd1, 3'd4, 3'd6, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        step();
        drive_beat(1'b0, '0, '0, '0, '0, '0);
        step();
        step();

        // Flush while holding a beat and offered a new one; write-back in the flush cycle survives
        drive_beat(1'b1, 23'h0000C3, 3'd1, 3'd1, 3'd1, 16'h0000);
        step();
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        drive_beat(1'b1, 23'h0000D4, 3'd2, 3'd2, 3'd2, 16'h0000);
        drive_wb(1'b1, 3'd7, 16'h7A7A);
        step();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        drive_wb(1'b0, '0, '0);
        drive_beat(1'b0, '0, '0, '0, '0, '0);
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        step();
        drive_beat(1'b1, 23'h0000E5, 3'd7, 3'd7, 3'd0, 16'h0000);
        step();
        check("flush_wb_read", 32'(bus.read_data2), 32'h7A7A);
        drive_beat(1'b0, '0, '0, '0, '0, '0);
        step();

        // Mixed traffic with random back-pressure and write-back
        for (int i = 0; i < 40; i++) begin
            drive_beat(1'($urandom_range(0, 3) != 0), 23'($urandom), 3'($urandom), 3'($urandom),
                       3'($urandom), 16'($urandom));
            drive_wb(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drive_beat(1'b0, '0, '0, '0, '0, '0);
        drive_wb(1'b0, '0, '0);
        bus.out_ready = 1'b1;
        step();
        step();
        check("beat_balance", 32'(rcvd + dropped), 32'(sent));
        check("sb_drained", 32'(sb.size()), 32'd0);

        // Reset during a stall drops the held beat and any write-back in flight
        drive_beat(1'b1, 23'h000111, 3'd3, 3'd1, 3'd2, 16'h0000);
        step();
        bus.out_ready = 1'b0;
        drive_beat(1'b1, 23'h000222, 3'd4, 3'd4, 3'd4, 16'h0000);
        step();
        drive_wb(1'b1, 3'd3, 16'h9999);
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_ctrl_out", 32'(bus.ctrl_out), 32'd0);
        check("mid_rst_read_data1", 32'(bus.read_data1), 32'd0);
        sb.delete();
        for (int i = 0; i < NUM_REGS; i++) mregs[i] = '0;
        @(posedge clk);
        #1;
        drive_wb(1'b0, '0, '0);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive_beat(1'b1, 23'h000333, 3'd3, 3'd1, 3'd4, 16'h0000);
        step();
        drive_beat(1'b0, '0, '0, '0, '0, '0);
        check("post_rst_r3", 32'(bus.read_data1), 32'd0);
        step();

        // Hardwired zero register: write to R0 is dropped, including the bypass path
        bus_z.wb_en    = 1'b1;
        bus_z.wb_addr  = 3'd0;
        bus_z.wb_data  = 16'hFFFF;
        bus_z.in_valid = 1'b1;
        bus_z.rsrc1    = 3'd0;
        bus_z.rsrc2    = 3'd0;
        @(posedge clk);
        #1;
        check("z_out_valid", 32'(bus_z.out_valid), 32'd1);
        check("z_bypass_r0_d1", 32'(bus_z.read_data1), 32'd0);
        check("z_bypass_r0_d2", 32'(bus_z.read_data2), 32'd0);
        bus_z.wb_addr = 3'd2;
        bus_z.wb_data = 16'hABCD;
        bus_z.rsrc2   = 3'd2;
        @(posedge clk);
        #1;
        check("z_bypass_r2", 32'(bus_z.read_data2), 32'hABCD);
        bus_z.wb_en = 1'b0;
        @(posedge clk);
        #1;
        check("z_stored_r0", 32'(bus_z.read_data1), 32'd0);
        check("z_stored_r2", 32'(bus_z.read_data2), 32'hABCD);
        bus_z.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("z_drained", 32'(bus_z.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
